// File: rtl/memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder_if
// Description : Request/acknowledge bus between the datapath (MAR/MDR side)
//               and the word-addressed memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_responder_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  Read;
   logic                  Write;
   logic [ADDR_WIDTH-1:0] Address;
   logic [31:0]           MDataout;
   logic [31:0]           MDatain;
   logic                  Mem_ready;
   logic                  Mem_err;

   // Datapath side: issues strobes, address and write data
   modport master (
      output Read, Write, Address, MDataout,
      input  MDatain, Mem_ready, Mem_err
   );

   // Memory side: consumes requests, returns read data and status
   modport slave (
      input  Read, Write, Address, MDataout,
      output MDatain, Mem_ready, Mem_err
   );
endinterface
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Single-port 32-bit word memory with programmable wait states
//               and a four-phase Read/Write strobe handshake to the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  wire logic          clock,
   input  wire logic          clear,
   memory_responder_if.slave  bus
);

   localparam int         c_DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [3:0]            r_count;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_is_write;
   logic [31:0]           r_mdatain;
   logic                  r_mem_err;
   logic [31:0]           r_mem [0:c_DEPTH-1];

   logic w_accept;
   logic w_reject;
   logic w_access;

   // Exactly one strobe in IDLE is a request; both together is rejected.
   assign w_accept = (r_state == IDLE) && (bus.Read ^ bus.Write);
   assign w_reject = (r_state == IDLE) && bus.Read && bus.Write;
   // The access happens on the edge that sees BUSY with the wait count spent.
   assign w_access = (r_state == BUSY) && (r_count == 4'd0);

   // State register; clear aborts any access in flight.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: DONE waits for both strobes low to close the handshake.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = BUSY;
         BUSY: if (w_access) w_state_next = DONE;
         DONE: if (!bus.Read && !bus.Write) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Capture the request at acceptance and count down the wait states.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_count    <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_is_write <= 1'b0;
      end else if (w_accept) begin
         r_count    <= c_WAIT_LOAD;
         r_addr     <= bus.Address;
         r_wdata    <= bus.MDataout;
         r_is_write <= bus.Write;
      end else if ((r_state == BUSY) && (r_count != 4'd0)) begin
         r_count    <= r_count - 4'd1;
      end
   end

   // Read data register holds the last read result; writes leave it alone.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_mdatain <= 32'd0;
      end else if (w_access && !r_is_write) begin
         r_mdatain <= r_mem[r_addr];
      end
   end

   // Rejection flag, high for the cycle following a both-strobes edge in IDLE.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_mem_err <= 1'b0;
      end else begin
         r_mem_err <= w_reject;
      end
   end

   // Storage array is not reset so its contents survive clear.
   always_ff @(posedge clock) begin
      if (w_access && r_is_write) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign bus.MDatain   = r_mdatain;
   assign bus.Mem_ready = (r_state == DONE);
   assign bus.Mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Directed self-checking bench for memory_responder, one
//               instance with default wait states and one with none.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

   logic clk;
   logic clear;
   int   n_tests;
   int   n_fail;

   memory_responder_if #(.ADDR_WIDTH(9)) b0 ();
   memory_responder_if #(.ADDR_WIDTH(9)) b1 ();

   memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) u_dut0 (
      .clock (clk),
      .clear (clear),
      .bus   (b0)
   );

   memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) u_dut1 (
      .clock (clk),
      .clear (clear),
      .bus   (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit rd, input bit wr,
                        input logic [8:0] addr, input logic [31:0] data);
      if (sel) begin
         b1.Read = rd; b1.Write = wr; b1.Address = addr; b1.MDataout = data;
      end else begin
         b0.Read = rd; b0.Write = wr; b0.Address = addr; b0.MDataout = data;
      end
   endtask

   // Full four-phase transfer; for reads 'data' is the expected read value.
   task automatic xfer(input string tag, input bit sel, input bit is_wr,
                       input logic [8:0] addr, input logic [31:0] data, input int exp_lat);
      int n;
      bit seen;
      drive(sel, !is_wr, is_wr, addr, data);
      tick();
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         tick();
         n++;
         seen = sel ? b1.Mem_ready : b0.Mem_ready;
      end
      check($sformatf("%s latency", tag), 32'(n), 32'(exp_lat));
      if (!is_wr)
         check($sformatf("%s rdata", tag), sel ? b1.MDatain : b0.MDatain, data);
      drive(sel, 1'b0, 1'b0, addr, data);
      tick();
      check($sformatf("%s ready_drop", tag), {31'd0, sel ? b1.Mem_ready : b0.Mem_ready}, 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clear   = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 9'h000, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 9'h000, 32'd0);
      #2;
      check("reset ready", {31'd0, b0.Mem_ready}, 32'd0);
      check("reset err",   {31'd0, b0.Mem_err},   32'd0);
      check("reset rdata", b0.MDatain,            32'd0);
      tick();
      tick();
      clear = 1'b0;

      // Write 0xDEADBEEF to 0x05A, ready 3 cycles after acceptance.
      drive(1'b0, 1'b0, 1'b1, 9'h05A, 32'hDEADBEEF);
      tick();
      check("wr accept ready", {31'd0, b0.Mem_ready}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("wr ready cyc%0d", k), {31'd0, b0.Mem_ready}, (k == 3) ? 32'd1 : 32'd0);
      end
      drive(1'b0, 1'b0, 1'b0, 9'h05A, 32'hDEADBEEF);
      tick();
      check("wr ready drop", {31'd0, b0.Mem_ready}, 32'd0);
      check("wr keeps rdata", b0.MDatain, 32'd0);

      // Read back 0x05A, then hold Read for 5 cycles in DONE.
      drive(1'b0, 1'b1, 1'b0, 9'h05A, 32'd0);
      tick();
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("rd ready cyc%0d", k), {31'd0, b0.Mem_ready}, (k == 3) ? 32'd1 : 32'd0);
      end
      check("rd data", b0.MDatain, 32'hDEADBEEF);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("hold ready %0d", k), {31'd0, b0.Mem_ready}, 32'd1);
         check($sformatf("hold rdata %0d", k), b0.MDatain, 32'hDEADBEEF);
      end
      drive(1'b0, 1'b0, 1'b0, 9'h05A, 32'd0);
      tick();
      check("hold release", {31'd0, b0.Mem_ready}, 32'd0);
      tick();
      check("hold stays idle", {31'd0, b0.Mem_ready}, 32'd0);

      // Both strobes in IDLE: one-cycle error, no access.
      drive(1'b0, 1'b1, 1'b1, 9'h05A, 32'h11111111);
      tick();
      check("both err", {31'd0, b0.Mem_err},   32'd1);
      check("both ready", {31'd0, b0.Mem_ready}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 9'h05A, 32'h11111111);
      tick();
      check("both err drop", {31'd0, b0.Mem_err}, 32'd0);
      check("both ready2", {31'd0, b0.Mem_ready}, 32'd0);
      check("both rdata", b0.MDatain, 32'hDEADBEEF);
      tick();
      check("both ready3", {31'd0, b0.Mem_ready}, 32'd0);
      xfer("both mem", 1'b0, 1'b0, 9'h05A, 32'hDEADBEEF, 3);

      // Clear during BUSY of a write must abort it.
      xfer("pre 010", 1'b0, 1'b1, 9'h010, 32'hCAFEF00D, 3);
      drive(1'b0, 1'b0, 1'b1, 9'h010, 32'h12345678);
      tick();
      tick();
      clear = 1'b1;
      #1;
      check("clr ready", {31'd0, b0.Mem_ready}, 32'd0);
      check("clr err",   {31'd0, b0.Mem_err},   32'd0);
      check("clr rdata", b0.MDatain,            32'd0);
      drive(1'b0, 1'b0, 1'b0, 9'h010, 32'd0);
      tick();
      clear = 1'b0;
      xfer("post clr rd", 1'b0, 1'b0, 9'h010, 32'hCAFEF00D, 3);

      // Address/data changes during BUSY are ignored.
      xfer("pre 002", 1'b0, 1'b1, 9'h002, 32'h22222222, 3);
      drive(1'b0, 1'b0, 1'b1, 9'h001, 32'hAAAA0001);
      tick();
      drive(1'b0, 1'b0, 1'b1, 9'h002, 32'hBBBB0002);
      tick();
      tick();
      tick();
      check("chg ready", {31'd0, b0.Mem_ready}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 9'h002, 32'hBBBB0002);
      tick();
      xfer("chg rd 001", 1'b0, 1'b0, 9'h001, 32'hAAAA0001, 3);
      xfer("chg rd 002", 1'b0, 1'b0, 9'h002, 32'h22222222, 3);

      // Zero wait states, top address.
      xfer("w0 wr 1ff", 1'b1, 1'b1, 9'h1FF, 32'h0000FFFF, 1);
      xfer("w0 rd 1ff", 1'b1, 1'b0, 9'h1FF, 32'h0000FFFF, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
